seg_frame_decoder: RTL and testbench

SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_glyph_decode.sv | 33 +++
 rtl/seg_frame_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_seg_frame_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment frame decoder.
// Segment patterns are active-high, bit0..6 = a..g (lit segment = 1).
package seg_pkg;

  localparam int NUM_DIG  = 4;
  localparam int SEC_ONES = 0;
  localparam int SEC_TENS = 1;
  localparam int MIN_ONES = 2;
  localparam int MIN_TENS = 3;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {GLYPH_DIGIT, GLYPH_BLANK, GLYPH_ERR} glyph_e;

  // One captured digit slot; dp is lit-high and stays 0 unless dp capture is built in.
  typedef struct packed {
    glyph_e     kind;
    logic [3:0] digit;
    logic       dp;
  } slot_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: active-low segment lines -> digit + glyph kind.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] digit,
  output glyph_e     kind
);

  logic [6:0] seg;
  assign seg = ~seg_n;

  // Match against the ten digit patterns and blank; anything else is illegal.
  always_comb begin
    digit = 4'd0;
    kind  = GLYPH_DIGIT;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: kind  = GLYPH_BLANK;
      default:   kind  = GLYPH_ERR;
    endcase
  end

endmodule

// File: rtl/seg_frame_decoder.sv
// Multiplexed 4-digit seven-segment display decoder (MM:SS).
// Settles on each anode selection, samples its cathodes once, assembles
// frames and publishes them after STABLE_FRAMES identical frames.
// Optional: define SEG_FRAME_DECODER_DP_CAPTURE_EN to capture decimal points.
module seg_frame_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] anode_vec,
  input  logic [7:0] cathode_vec,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [3:0] blank_vec,
  output logic [3:0] dp_vec,
  output logic       err,
  output logic       frame_valid
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = $clog2(STABLE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  state_e                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [3:0]              sel, sel_nxt;
  logic                    sample;
  logic [3:0]              sel_lo;
  logic                    sel_valid;
  logic [1:0]              sel_idx;

  logic [3:0]              g_digit;
  glyph_e                  g_kind;
  slot_t                   new_slot;
  slot_t [NUM_DIG-1:0]     slots, slots_w, prev_frame;
  logic [NUM_DIG-1:0]      cap, cap_w;
  logic                    prev_vld, frame_done, same;
  logic [SW-1:0]           stab, stab_w;
  logic                    accept;
  logic [NUM_DIG-1:0][3:0] acc, acc_w;
  logic [5:0]              min_w, sec_w;
  logic [3:0]              blank_w;
  logic                    err_w;

  // Exactly one anode line low selects a digit.
  assign sel_lo    = ~anode_vec;
  assign sel_valid = (sel_lo != 4'd0) && ((sel_lo & (sel_lo - 4'd1)) == 4'd0);

  // Index of the selected digit (meaningful only when sel_valid).
  always_comb begin
    sel_idx = 2'd0;
    for (int i = 0; i < NUM_DIG; i++)
      if (sel_lo[i]) sel_idx = 2'(i);
  end

  seg_glyph_decode u_glyph (
    .seg_n (cathode_vec[6:0]),
    .digit (g_digit),
    .kind  (g_kind)
  );

  // Settle FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 4'hF;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
    end
  end

  // Settle FSM next state: any new selection restarts the count at 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    sample    = 1'b0;
    if (!sel_valid) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
          sel_nxt   = anode_vec;
        end
        SETTLE: begin
          if (anode_vec != sel) begin
            cnt_nxt = '0;
            sel_nxt = anode_vec;
          end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            sample    = 1'b1;
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HOLD: begin
          if (anode_vec != sel) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
            sel_nxt   = anode_vec;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef SEG_FRAME_DECODER_DP_CAPTURE_EN
  assign new_slot = '{kind: g_kind, digit: g_digit, dp: ~cathode_vec[7]};
`else
  logic dp_unused;
  assign dp_unused = cathode_vec[7];
  assign new_slot  = '{kind: g_kind, digit: g_digit, dp: 1'b0};
`endif

  // Frame assembly, stability count and candidate output values.
  // An out-of-range tens digit is flagged and keeps its previously accepted value.
  always_comb begin
    slots_w = slots;
    cap_w   = cap;
    if (sample) begin
      slots_w[sel_idx] = new_slot;
      cap_w[sel_idx]   = 1'b1;
    end
    frame_done = sample && (cap_w == 4'hF);
    same       = prev_vld && (slots_w == prev_frame);
    if (!same)                           stab_w = SW'(1);
    else if (stab == SW'(STABLE_FRAMES)) stab_w = stab;
    else                                 stab_w = stab + SW'(1);
    accept = frame_done && (stab_w == SW'(STABLE_FRAMES));

    err_w = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      acc_w[i]   = acc[i];
      blank_w[i] = (slots_w[i].kind == GLYPH_BLANK);
      if (slots_w[i].kind == GLYPH_ERR) err_w = 1'b1;
      if (slots_w[i].kind == GLYPH_DIGIT) begin
        if ((i == SEC_TENS || i == MIN_TENS) && slots_w[i].digit > 4'd5)
          err_w = 1'b1;
        else
          acc_w[i] = slots_w[i].digit;
      end
    end
    min_w = 6'(acc_w[MIN_TENS]) * 6'd10 + 6'(acc_w[MIN_ONES]);
    sec_w = 6'(acc_w[SEC_TENS]) * 6'd10 + 6'(acc_w[SEC_ONES]);
  end

  // Capture slots; a completed frame clears the captured bits and becomes the reference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots      <= '0;
      cap        <= '0;
      prev_frame <= '0;
      prev_vld   <= 1'b0;
      stab       <= '0;
    end else if (sample) begin
      slots <= slots_w;
      if (frame_done) begin
        cap        <= '0;
        prev_frame <= slots_w;
        prev_vld   <= 1'b1;
        stab       <= stab_w;
      end else begin
        cap <= cap_w;
      end
    end
  end

  // Publish accepted frames; frame_valid is a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      min         <= '0;
      sec         <= '0;
      blank_vec   <= '0;
      err         <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= accept;
      if (accept) begin
        acc       <= acc_w;
        min       <= min_w;
        sec       <= sec_w;
        blank_vec <= blank_w;
        err       <= err_w;
      end
    end
  end

`ifdef SEG_FRAME_DECODER_DP_CAPTURE_EN
  // Decimal points of the accepted frame, lit = 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dp_vec <= '0;
    else if (accept) dp_vec <= {slots_w[3].dp, slots_w[2].dp, slots_w[1].dp, slots_w[0].dp};
  end
`else
  assign dp_vec = 4'b0000;
`endif

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Directed bench for seg_frame_decoder (default parameters, dp capture off).
module tb_seg_frame_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] anode_vec;
  logic [7:0] cathode_vec;
  logic [5:0] min, sec;
  logic [3:0] blank_vec, dp_vec;
  logic       err, frame_valid;

  // Active-low cathode codes, dp off.
  localparam logic [7:0] C1 = 8'hF9;
  localparam logic [7:0] C2 = 8'hA4;
  localparam logic [7:0] C3 = 8'hB0;
  localparam logic [7:0] C4 = 8'h99;
  localparam logic [7:0] C7 = 8'hF8;
  localparam logic [7:0] CB = 8'hFF;

  int n_chk = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int base;

  seg_frame_decoder #(.SETTLE_CYCLES(16), .STABLE_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .anode_vec   (anode_vec),
    .cathode_vec (cathode_vec),
    .min         (min),
    .sec         (sec),
    .blank_vec   (blank_vec),
    .dp_vec      (dp_vec),
    .err         (err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  // Count frame_valid cycles.
  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic show(input int idx, input logic [7:0] cath, input int n);
    logic [3:0] one;
    one         = 4'b0001 << idx;
    anode_vec   = ~one;
    cathode_vec = cath;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    anode_vec = 4'hF;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] c3, input logic [7:0] c2,
                       input logic [7:0] c1, input logic [7:0] c0);
    idle(2);
    show(3, c3, 20);
    show(2, c2, 20);
    show(1, c1, 20);
    show(0, c0, 20);
  endtask

  initial begin
    rst         = 1'b0;
    anode_vec   = 4'hF;
    cathode_vec = CB;
    repeat (3) @(negedge clk);
    chk("rst_min", min, 0);
    chk("rst_sec", sec, 0);
    chk("rst_blank", blank_vec, 0);
    chk("rst_dp", dp_vec, 0);
    chk("rst_err", err, 0);
    chk("rst_fv", frame_valid, 0);
    rst = 1'b1;
    @(negedge clk);

    // 12:34 twice: first frame only primes the stability count
    base = fv_cnt;
    frame(C1, C2, C3, C4);
    chk("f1_no_fv", fv_cnt - base, 0);
    chk("f1_min", min, 0);
    frame(C1, C2, C3, C4);
    chk("f2_fv", fv_cnt - base, 1);
    chk("f2_min", min, 12);
    chk("f2_sec", sec, 34);
    chk("f2_err", err, 0);
    chk("f2_blank", blank_vec, 0);
    chk("f2_dp", dp_vec, 0);

    // saturated count pulses once per frame
    base = fv_cnt;
    frame(C1, C2, C3, C4);
    chk("sat_fv", fv_cnt - base, 1);

    // minutes tens dropped after 10 cycles: no frame until it is held long enough
    base = fv_cnt;
    idle(2);
    show(3, C1, 10);
    show(2, C2, 20);
    show(1, C3, 20);
    show(0, C4, 20);
    chk("short_no_frame", fv_cnt - base, 0);
    show(3, C1, 20);
    chk("short_recovered", fv_cnt - base, 1);

    // two anodes low mid-frame: idle, partial captures kept
    base = fv_cnt;
    idle(2);
    show(3, C1, 20);
    show(2, C2, 20);
    anode_vec   = 4'b0011;
    cathode_vec = C7;
    repeat (50) @(negedge clk);
    show(1, C3, 20);
    chk("multi_no_frame", fv_cnt - base, 0);
    show(0, C4, 20);
    chk("multi_frame", fv_cnt - base, 1);

    // seconds tens = 7 -> err, sec held
    base = fv_cnt;
    frame(C1, C2, C7, C4);
    chk("e1_no_fv", fv_cnt - base, 0);
    chk("e1_sec", sec, 34);
    frame(C1, C2, C7, C4);
    chk("e2_fv", fv_cnt - base, 1);
    chk("e2_err", err, 1);
    chk("e2_sec", sec, 34);
    chk("e2_min", min, 12);

    // blank minutes digits
    base = fv_cnt;
    frame(CB, CB, C3, C4);
    frame(CB, CB, C3, C4);
    chk("b_fv", fv_cnt - base, 1);
    chk("b_blank", blank_vec, 4'b1100);
    chk("b_min", min, 12);
    chk("b_sec", sec, 34);
    chk("b_err", err, 0);

    // reset after three captured digits
    idle(2);
    show(3, C1, 20);
    show(2, C2, 20);
    show(1, C3, 20);
    show(0, C4, 5);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_min", min, 0);
    chk("mrst_sec", sec, 0);
    chk("mrst_blank", blank_vec, 0);
    chk("mrst_err", err, 0);
    chk("mrst_fv", frame_valid, 0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    base = fv_cnt;
    show(0, C4, 20);
    show(3, C1, 20);
    show(2, C2, 20);
    show(1, C3, 20);
    chk("mrst_f1_no_fv", fv_cnt - base, 0);
    show(0, C4, 20);
    chk("mrst_partial_no_fv", fv_cnt - base, 0);
    show(3, C1, 20);
    show(2, C2, 20);
    show(1, C3, 20);
    chk("mrst_f2_fv", fv_cnt - base, 1);
    chk("mrst_f2_min", min, 12);
    chk("mrst_f2_sec", sec, 34);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
